zap_wb_arbiter: RTL

ZAP_WB_ARBITER -- requirements
Module: zap_wb_arbiter

---
 rtl/zap_wb_arbiter_pkg.sv | 20 ++
 rtl/zap_rr_picker.sv | 31 +++
 rtl/zap_wb_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/zap_wb_arbiter_pkg.sv
// rtl/zap_wb_arbiter_pkg.sv - shared ZAP Wishbone arbiter types and constants
package zap_wb_arbiter_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_BURST   = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Pointer width covers the largest supported master count (4).
  localparam int PTR_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/zap_rr_picker.sv
// rtl/zap_rr_picker.sv - combinational round-robin one-hot selector
module zap_rr_picker
  import zap_wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] gnt
);

  logic [3:0]       req_ext;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan from ptr upward, wrapping at NUM_MASTERS; first requester wins.
  always_comb begin
    req_ext = 4'(req);
    gnt     = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_MASTERS);
      if (!found && req_ext[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zap_wb_arbiter.sv
// rtl/zap_wb_arbiter.sv - round-robin Wishbone master arbiter
// Optional bus watchdog enabled by macro ZAP_WB_ARB_WATCHDOG_EN.
module zap_wb_arbiter
  import zap_wb_arbiter_pkg::*;
#(
  parameter int          NUM_MASTERS    = 3,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd256
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_MASTERS-1:0]    i_m_cyc,
  input  logic [NUM_MASTERS-1:0]    i_m_stb,
  input  logic [NUM_MASTERS-1:0]    i_m_wen,
  input  logic [4*NUM_MASTERS-1:0]  i_m_sel,
  input  logic [32*NUM_MASTERS-1:0] i_m_adr,
  input  logic [32*NUM_MASTERS-1:0] i_m_dat,
  input  logic [3*NUM_MASTERS-1:0]  i_m_cti,
  output logic [NUM_MASTERS-1:0]    o_m_ack,
  output logic [NUM_MASTERS-1:0]    o_m_err,
  output logic [31:0]               o_m_dat,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_wen,
  output logic [3:0]                o_wb_sel,
  output logic [31:0]               o_wb_adr,
  output logic [31:0]               o_wb_dat,
  output logic [2:0]                o_wb_cti,
  input  logic [31:0]               i_wb_dat,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_err,
  output logic [NUM_MASTERS-1:0]    o_grant,
  output logic                      o_timeout
);

  arb_state_t             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt, pick;
  logic [PTR_W-1:0]       rr_ptr, rr_nxt, owner_idx;
  logic                   owner_cyc, owner_stb, owner_wen;
  logic [3:0]             owner_sel;
  logic [31:0]            owner_adr, owner_dat;
  logic [2:0]             owner_cti;
  logic                   wdt_fire, release_bus, bus_on;

  zap_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req (i_m_cyc),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  always_comb begin
    owner_idx = '0;
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    owner_wen = 1'b0;
    owner_sel = '0;
    owner_adr = '0;
    owner_dat = '0;
    owner_cti = CTI_EOB;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (o_grant[i]) begin
        owner_idx = PTR_W'(i);
        owner_cyc = i_m_cyc[i];
        owner_stb = i_m_stb[i];
        owner_wen = i_m_wen[i];
        owner_sel = i_m_sel[4*i +: 4];
        owner_adr = i_m_adr[32*i +: 32];
        owner_dat = i_m_dat[32*i +: 32];
        owner_cti = i_m_cti[3*i +: 3];
      end
    end
  end

`ifdef ZAP_WB_ARB_WATCHDOG_EN
  logic [15:0] wdt_cnt;
  logic        timeout_q;

  assign wdt_fire  = (state == BUSY) && (wdt_cnt == TIMEOUT_CYCLES[15:0]);
  assign o_timeout = timeout_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wdt_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != BUSY || i_wb_ack || release_bus)
        wdt_cnt <= '0;
      else if (o_wb_stb)
        wdt_cnt <= wdt_cnt + 16'd1;
      if (wdt_fire)
        timeout_q <= 1'b1;
    end
  end
`else
  assign wdt_fire  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Ownership ends when the owner drops cyc or the watchdog expires.
  assign release_bus = (state == BUSY) && (!owner_cyc || wdt_fire);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      o_grant <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      o_grant <= grant_nxt;
      rr_ptr  <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = o_grant;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (|i_m_cyc) begin
          state_nxt = BUSY;
          grant_nxt = pick;
        end
      end
      BUSY: begin
        if (release_bus) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          rr_nxt    = next_ptr(owner_idx, NUM_MASTERS);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign bus_on   = (state == BUSY) && !wdt_fire;
  assign o_wb_cyc = bus_on & owner_cyc;
  assign o_wb_stb = bus_on & owner_stb;
  assign o_wb_cti = bus_on ? owner_cti : CTI_EOB;
  assign o_wb_wen = owner_wen;
  assign o_wb_sel = owner_sel;
  assign o_wb_adr = owner_adr;
  assign o_wb_dat = owner_dat;

  // o_grant is zero outside BUSY, so responses never leak to a non-owner.
  assign o_m_ack = o_grant & {NUM_MASTERS{i_wb_ack | wdt_fire}};
  assign o_m_err = o_grant & {NUM_MASTERS{(i_wb_ack & i_wb_err) | wdt_fire}};
  assign o_m_dat = i_wb_dat;

  a_err_needs_ack: assert property (@(posedge i_clk) disable iff (!i_reset_n)
                                    !(i_wb_err && !i_wb_ack));

endmodule
